// File: rtl/bsg_link_upstream_ch_tx.sv
// ---------------------------------------------------------------------------
// bsg_link_upstream_ch_tx
//
// Transmit end of one link channel. Core words arrive over a valid/ready
// handshake and leave as CHANNEL_WIDTH_P-bit beats, least-significant beat
// first, on a registered io_data_o/io_valid_o pair. Each word spends
// E = WIDTH_P/(2*CHANNEL_WIDTH_P) credits against the downstream receiver's
// async FIFO. Credits come back on a toggle-encoded token line: every level
// change returns 2^LG_CREDIT_TO_TOKEN_DECIMATION_P credits.
//
// Ports:
//   clk             clock
//   rst             synchronous, active-high reset
//   core_data_i     word to send
//   core_valid_i    word present
//   core_ready_o    word accepted when valid & ready
//   io_data_o       serialized beat (registered)
//   io_valid_o      beat valid (registered)
//   token_i         toggle line from the receiver, one token per level change
//   credit_count_o  current credits
//   overflow_err_o  sticky credit-overflow flag, cleared only by rst
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no word in flight; ready whenever a word's worth of credit exists
// S_SEND | beats on the wire; on the cycle the last beat is shown, a new
//        | word may be accepted so its beat 0 follows without a bubble
// ---------------------------------------------------------------------------
module bsg_link_upstream_ch_tx #(
  parameter int WIDTH_P                         = 32,
  parameter int CHANNEL_WIDTH_P                 = 8,
  parameter int LG_FIFO_DEPTH_P                 = 6,
  parameter int LG_CREDIT_TO_TOKEN_DECIMATION_P = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH_P-1:0]         core_data_i,
  input  logic                       core_valid_i,
  output logic                       core_ready_o,
  output logic [CHANNEL_WIDTH_P-1:0] io_data_o,
  output logic                       io_valid_o,
  input  logic                       token_i,
  output logic [LG_FIFO_DEPTH_P:0]   credit_count_o,
  output logic                       overflow_err_o
);

  localparam int E_LP      = WIDTH_P / (2 * CHANNEL_WIDTH_P);
  localparam int B_LP      = 2 * E_LP;
  localparam int MAX_LP    = 1 << LG_FIFO_DEPTH_P;
  localparam int T_LP      = 1 << LG_CREDIT_TO_TOKEN_DECIMATION_P;
  localparam int CRED_W_LP = LG_FIFO_DEPTH_P + 1;
  // Wide enough to hold credits + T before clamping, whichever of the two
  // exponents is larger.
  localparam int SUM_W_LP  = ((LG_FIFO_DEPTH_P > LG_CREDIT_TO_TOKEN_DECIMATION_P) ?
                              LG_FIFO_DEPTH_P : LG_CREDIT_TO_TOKEN_DECIMATION_P) + 2;
  localparam int BCNT_W_LP = $clog2(B_LP);

  localparam logic [CRED_W_LP-1:0] CRED_MAX_LP = CRED_W_LP'(MAX_LP);
  localparam logic [CRED_W_LP-1:0] CRED_E_LP   = CRED_W_LP'(E_LP);
  localparam logic [SUM_W_LP-1:0]  SUM_MAX_LP  = SUM_W_LP'(MAX_LP);
  localparam logic [SUM_W_LP-1:0]  SUM_T_LP    = SUM_W_LP'(T_LP);
  localparam logic [SUM_W_LP-1:0]  SUM_E_LP    = SUM_W_LP'(E_LP);
  localparam logic [BCNT_W_LP-1:0] BEATS_LP    = BCNT_W_LP'(B_LP - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e                     r_state;
  state_e                     w_state_n;

  logic [CRED_W_LP-1:0]       r_credits;
  logic                       r_overflow;
  logic                       r_token_q;
  logic [WIDTH_P-1:0]         r_shift;
  logic [BCNT_W_LP-1:0]       r_beats_left;
  logic [CHANNEL_WIDTH_P-1:0] r_io_data;
  logic                       r_io_valid;

  logic                       w_has_credit;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_shift;
  logic                       w_token;
  logic [SUM_W_LP-1:0]        w_cred_sum;
  logic                       w_over;
  logic [CRED_W_LP-1:0]       w_cred_next;

  // Ready looks only at credits already registered; a token arriving this
  // cycle is not usable until the next one.
  assign w_has_credit = (r_credits >= CRED_E_LP);
  assign w_token      = (token_i != r_token_q);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_n = r_state;
    w_ready   = 1'b0;
    w_accept  = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready  = w_has_credit;
        w_accept = core_valid_i & w_has_credit;
        if (w_accept) w_state_n = S_SEND;
      end
      S_SEND: begin
        if (r_beats_left != '0) begin
          w_shift = 1'b1;
        end else begin
          // Last beat is on the wire this cycle.
          w_ready  = w_has_credit;
          w_accept = core_valid_i & w_has_credit;
          if (!w_accept) w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Serializer. An accepted word drives beat 0 straight from core_data_i so
  // it appears the cycle after acceptance; the shift register then supplies
  // the remaining beats while the down-counter runs to zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_io_data    <= '0;
      r_io_valid   <= 1'b0;
      r_shift      <= '0;
      r_beats_left <= '0;
    end else if (w_accept) begin
      r_io_data    <= core_data_i[CHANNEL_WIDTH_P-1:0];
      r_io_valid   <= 1'b1;
      r_shift      <= core_data_i >> CHANNEL_WIDTH_P;
      r_beats_left <= BEATS_LP;
    end else if (w_shift) begin
      r_io_data    <= r_shift[CHANNEL_WIDTH_P-1:0];
      r_io_valid   <= 1'b1;
      r_shift      <= r_shift >> CHANNEL_WIDTH_P;
      r_beats_left <= r_beats_left - BCNT_W_LP'(1);
    end else begin
      r_io_valid   <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Credit accounting. Spend happens only with credits >= E, so the sum never
  // goes negative; a token can push it past MAX, which clamps and latches the
  // error flag.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cred_sum = SUM_W_LP'(r_credits)
               + (w_token  ? SUM_T_LP : '0)
               - (w_accept ? SUM_E_LP : '0);
    w_over      = (w_cred_sum > SUM_MAX_LP);
    w_cred_next = w_over ? CRED_MAX_LP : w_cred_sum[CRED_W_LP-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits  <= CRED_MAX_LP;
      r_overflow <= 1'b0;
      r_token_q  <= token_i;
    end else begin
      r_credits  <= w_cred_next;
      r_overflow <= r_overflow | w_over;
      r_token_q  <= token_i;
    end
  end

  assign core_ready_o   = w_ready;
  assign io_data_o      = r_io_data;
  assign io_valid_o     = r_io_valid;
  assign credit_count_o = r_credits;
  assign overflow_err_o = r_overflow;

endmodule

// File: tb/tb_bsg_link_upstream_ch_tx.sv
// ---------------------------------------------------------------------------
// Directed bench for bsg_link_upstream_ch_tx at default parameters
// (32-bit words, 8-bit beats, 64 credits, 8 credits per token).
// Inputs change on the falling edge; outputs are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_bsg_link_upstream_ch_tx;

  logic        clk;
  logic        rst;
  logic [31:0] core_data_i;
  logic        core_valid_i;
  logic        core_ready_o;
  logic [7:0]  io_data_o;
  logic        io_valid_o;
  logic        token_i;
  logic [6:0]  credit_count_o;
  logic        overflow_err_o;

  int n_vec = 0;
  int n_err = 0;

  bsg_link_upstream_ch_tx #(
    .WIDTH_P                         (32),
    .CHANNEL_WIDTH_P                 (8),
    .LG_FIFO_DEPTH_P                 (6),
    .LG_CREDIT_TO_TOKEN_DECIMATION_P (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .core_data_i    (core_data_i),
    .core_valid_i   (core_valid_i),
    .core_ready_o   (core_ready_o),
    .io_data_o      (io_data_o),
    .io_valid_o     (io_valid_o),
    .token_i        (token_i),
    .credit_count_o (credit_count_o),
    .overflow_err_o (overflow_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] wgen(input int i);
    return {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
  endfunction

  // Call with the word on core_data_i and core_valid_i = 1 in a cycle where
  // it will be accepted. Checks its four beats on consecutive cycles and the
  // credit count right after acceptance; returns in the cycle that shows the
  // last beat, with nxt already presented on core_data_i.
  task automatic expect_word(input logic [31:0] cur, input logic [31:0] nxt, input int cr);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) core_data_i = nxt;
      check("beat_valid", 32'(io_valid_o), 32'd1);
      check("beat_data", 32'(io_data_o), 32'(cur[k*8 +: 8]));
      if (k == 0) check("credits_after_accept", 32'(credit_count_o), 32'(cr));
      if (k < 3)  check("ready_mid_word", 32'(core_ready_o), 32'd0);
    end
  endtask

  initial begin
    rst          = 1'b1;
    core_data_i  = '0;
    core_valid_i = 1'b0;
    token_i      = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_credits", 32'(credit_count_o), 32'd64);
    check("rst_io_valid", 32'(io_valid_o), 32'd0);
    check("rst_io_data", 32'(io_data_o), 32'd0);
    check("rst_overflow", 32'(overflow_err_o), 32'd0);
    check("rst_ready", 32'(core_ready_o), 32'd1);

    // 1: single word, LSB beat first
    rst          = 1'b0;
    core_valid_i = 1'b1;
    core_data_i  = 32'hDDCC_BBAA;
    check("t1_ready", 32'(core_ready_o), 32'd1);
    step();
    core_valid_i = 1'b0;
    core_data_i  = 32'h1111_1111;
    check("t1_v0", 32'(io_valid_o), 32'd1);
    check("t1_b0", 32'(io_data_o), 32'hAA);
    check("t1_cred", 32'(credit_count_o), 32'd62);
    step();
    check("t1_b1", 32'(io_data_o), 32'hBB);
    step();
    check("t1_b2", 32'(io_data_o), 32'hCC);
    step();
    check("t1_v3", 32'(io_valid_o), 32'd1);
    check("t1_b3", 32'(io_data_o), 32'hDD);
    step();
    check("t1_idle_valid", 32'(io_valid_o), 32'd0);
    check("t1_idle_hold", 32'(io_data_o), 32'hDD);
    check("t1_idle_cred", 32'(credit_count_o), 32'd62);

    // 2: 32 back-to-back words drain all credits
    rst = 1'b1;
    step();
    rst          = 1'b0;
    core_valid_i = 1'b1;
    core_data_i  = wgen(0);
    for (int i = 0; i < 32; i++) expect_word(wgen(i), wgen(i + 1), 62 - 2 * i);
    check("t2_cred_zero", 32'(credit_count_o), 32'd0);
    check("t2_ready_33rd", 32'(core_ready_o), 32'd0);
    step();
    check("t2_stall_valid", 32'(io_valid_o), 32'd0);
    check("t2_stall_ready", 32'(core_ready_o), 32'd0);
    step();
    check("t2_stall_ready2", 32'(core_ready_o), 32'd0);

    // 3: one token from zero credits, pending word goes the cycle after
    token_i = 1'b1;
    step();
    check("t3_cred_token", 32'(credit_count_o), 32'd8);
    check("t3_ready", 32'(core_ready_o), 32'd1);
    check("t3_no_beat_yet", 32'(io_valid_o), 32'd0);
    expect_word(wgen(32), wgen(33), 6);
    expect_word(wgen(33), wgen(34), 4);
    expect_word(wgen(34), wgen(35), 2);

    // 4: token coincident with an accept at 2 credits, then no beat gap
    check("t4_cred_pre", 32'(credit_count_o), 32'd2);
    check("t4_ready", 32'(core_ready_o), 32'd1);
    token_i = 1'b0;
    expect_word(wgen(35), wgen(36), 8);
    expect_word(wgen(36), 32'h0, 6);
    core_valid_i = 1'b0;
    step();
    check("t4_idle_valid", 32'(io_valid_o), 32'd0);
    check("t4_idle_cred", 32'(credit_count_o), 32'd6);

    // 5: token at 60 credits clamps and sets the sticky flag
    rst = 1'b1;
    step();
    rst          = 1'b0;
    core_valid_i = 1'b1;
    core_data_i  = 32'h1234_5678;
    expect_word(32'h1234_5678, 32'h9ABC_DEF0, 62);
    expect_word(32'h9ABC_DEF0, 32'h0, 60);
    core_valid_i = 1'b0;
    step();
    check("t5_cred60", 32'(credit_count_o), 32'd60);
    check("t5_ovf_pre", 32'(overflow_err_o), 32'd0);
    token_i = ~token_i;
    step();
    check("t5_clamp", 32'(credit_count_o), 32'd64);
    check("t5_ovf_set", 32'(overflow_err_o), 32'd1);
    step();
    check("t5_ovf_hold", 32'(overflow_err_o), 32'd1);
    token_i = ~token_i;
    step();
    check("t5_clamp2", 32'(credit_count_o), 32'd64);
    core_valid_i = 1'b1;
    core_data_i  = 32'h0F1E_2D3C;
    expect_word(32'h0F1E_2D3C, 32'h0, 62);
    core_valid_i = 1'b0;
    check("t5_ovf_sticky", 32'(overflow_err_o), 32'd1);
    step();

    // 6: reset after the second beat drops the rest of the word
    core_valid_i = 1'b1;
    core_data_i  = 32'hCAFE_F00D;
    step();
    core_valid_i = 1'b0;
    check("t6_b0", 32'(io_data_o), 32'h0D);
    step();
    check("t6_b1", 32'(io_data_o), 32'hF0);
    check("t6_b1_valid", 32'(io_valid_o), 32'd1);
    rst = 1'b1;
    step();
    check("t6_valid_drop", 32'(io_valid_o), 32'd0);
    check("t6_cred", 32'(credit_count_o), 32'd64);
    check("t6_ready", 32'(core_ready_o), 32'd1);
    check("t6_ovf_clr", 32'(overflow_err_o), 32'd0);
    rst = 1'b0;
    step();
    check("t6_stays_idle", 32'(io_valid_o), 32'd0);
    core_valid_i = 1'b1;
    core_data_i  = 32'h8765_4321;
    expect_word(32'h8765_4321, 32'h0, 62);
    core_valid_i = 1'b0;
    step();
    check("t6_end_idle", 32'(io_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_link_upstream_ch_tx.md
Name: bsg_link_upstream_ch_tx

Overview:
Transmit end of one link channel. It accepts core words over a valid/ready handshake and serializes each word into CHANNEL_WIDTH_P-bit beats on io_data_o/io_valid_o. It spends credits against the downstream receiver's async FIFO and replenishes them from the receiver's toggle-encoded token line. It is the single-clock counterpart of the downstream channel and feeds its io_data_i/io_valid_i directly.

Parameters:
WIDTH_P, 32, core word width; must be a multiple of 2*CHANNEL_WIDTH_P.
CHANNEL_WIDTH_P, 8, io beat width.
LG_FIFO_DEPTH_P, 6, log2 of downstream FIFO entries; one entry = 2 beats = one credit.
LG_CREDIT_TO_TOKEN_DECIMATION_P, 3, each token toggle returns 2^this credits.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
core_data_i  in  WIDTH_P  word to send
core_valid_i  in  1  word present
core_ready_o  out  1  word accepted when valid&ready
io_data_o  out  CHANNEL_WIDTH_P  serialized beat, registered
io_valid_o  out  1  beat valid, registered
token_i  in  1  toggle line from receiver; each level change = one token
credit_count_o  out  LG_FIFO_DEPTH_P+1  current credits
overflow_err_o  out  1  sticky credit-overflow flag

Behaviour:
- Definitions: E = WIDTH_P/(2*CHANNEL_WIDTH_P) credits per word (2 at default); B = 2E beats per word (4 at default); MAX = 2^LG_FIFO_DEPTH_P (64).
- Reset values: credits = MAX; io_valid_o = 0; io_data_o = 0; overflow_err_o = 0; FSM = IDLE; beat counter = 0; token_q = token_i sampled at reset.
- FSM IDLE: core_ready_o = (credits >= E). On valid&ready: latch word into shift register, credits -= E, go to SEND.
- FSM SEND: each cycle drives beat k = word[k*CW +: CW], least-significant beat first, with io_valid_o = 1 registered. Latency: word accepted in cycle N, beats appear in cycles N+1 .. N+B.
- Back-to-back: during the cycle that registers the last beat, core_ready_o = (credits_next_available >= E). If a word is accepted then, its beat 0 follows in the next cycle with no bubble. Otherwise return to IDLE.
- core_ready_o is 0 in SEND except on the last-beat cycle. core_data_i is ignored when not accepted.
- Token detection: a token occurs when token_i != token_q. token_q <= token_i every cycle. A token adds T = 2^LG_CREDIT_TO_TOKEN_DECIMATION_P credits (8).
- Same-cycle events: token and spend in the same cycle give credits_next = credits + T - E. The ready decision uses credits before the token is added, i.e. the token takes effect from the next cycle.
- Credit width: LG_FIFO_DEPTH_P+1 bits, unsigned. Spend only occurs when credits >= E, so no underflow.
- Overflow: if credits + T (- E) > MAX, clamp credits to MAX and set overflow_err_o = 1. overflow_err_o stays set until rst.
- io_valid_o = 0 and io_data_o holds its last value while idle.
- Reset mid-word: the remaining beats are dropped, io_valid_o = 0 on the next edge, credits return to MAX.

Test Plan:
1. Reset, then core_valid_i = 1 with 0xDDCCBBAA -> accepted on the first cycle; io beats 0xAA, 0xBB, 0xCC, 0xDD in cycles 1-4; credit_count_o drops 64 -> 62.
2. Stream 32 words with no tokens -> all 32 accepted back-to-back, 128 contiguous valid beats; credits reach 0; core_ready_o = 0 for the 33rd word.
3. From 0 credits, toggle token_i once -> credits = 8 the next cycle; the pending word is accepted one cycle later; credits = 6.
4. Token toggle in the same cycle as an accept with credits = 2 -> credits_next = 8 (2 + 8 - 2); no beat gap on the following word.
5. With credits = 60, toggle token_i -> credits clamp to 64 and overflow_err_o = 1; it stays 1 until rst.
6. Assert rst after the 2nd beat of a word -> io_valid_o = 0 the next cycle, credits = 64, FSM in IDLE, core_ready_o = 1.
